pmp_csr: RTL and testbench

//  Owns the PMP CSR state (pmpcfg0, pmpcfg2, pmpaddr0..15) written and read by the CSR unit.

---
 rtl/pmp_pkg.sv | 41 ++++
 rtl/pmp_cfg_lane.sv | 27 ++
 rtl/pmp_csr.sv | 153 +++++++++++++++
 tb/tb_pmp_csr.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// PMP CSR shared definitions: CSR addresses, csr_op encodings, cfg field layout.
// Contents: address constants, op codes, A-field codes, cfg bit positions,
//           and the read-modify-write helper used by the CSR block.
package pmp_pkg;

    localparam logic [11:0] PMPCFG0      = 12'h3A0;
    localparam logic [11:0] PMPCFG2      = 12'h3A2;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    localparam int CFG_R    = 0;
    localparam int CFG_W    = 1;
    localparam int CFG_X    = 2;
    localparam int CFG_A_LO = 3;
    localparam int CFG_A_HI = 4;
    localparam int CFG_L    = 7;

    localparam logic [1:0] PRIV_M = 2'b11;

    // Value a CSR op would produce from the current register contents.
    function automatic logic [63:0] csr_apply(input logic [1:0]  op,
                                              input logic [63:0] old_val,
                                              input logic [63:0] wdata);
        case (op)
            OP_RW:   return wdata;
            OP_RS:   return old_val | wdata;
            OP_RC:   return old_val & ~wdata;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/pmp_cfg_lane.sv
// One pmpcfg byte lane: legalises a written cfg byte and reports whether it changed.
// Ports: old_cfg (stored byte), new_cfg (requested byte), wr_en (write allowed),
//        cfg_out (next stored byte), changed (cfg_out differs from old_cfg).
module pmp_cfg_lane
    import pmp_pkg::*;
(
    input  logic [7:0] old_cfg,
    input  logic [7:0] new_cfg,
    input  logic       wr_en,
    output logic [7:0] cfg_out,
    output logic       changed
);

    logic [7:0] legal;

    always_comb begin
        legal      = new_cfg;
        legal[6:5] = 2'b00;
        // W without R is a reserved combination; drop W, keep everything else.
        if (!legal[CFG_R] && legal[CFG_W]) begin
            legal[CFG_W] = 1'b0;
        end
        cfg_out = wr_en ? legal : old_cfg;
        changed = (cfg_out != old_cfg);
    end

endmodule

// File: rtl/pmp_csr.sv
// PMP CSR state: pmpcfg0/pmpcfg2 and pmpaddr0..15 with WARL masking and lock rules.
// Ports: CSR request (csr_req/addr/op/wdata, priv) -> registered response one cycle
//        later (csr_ack/rdata/illegal), pmp_upd change pulse, flat cfg/addr buses.
module pmp_csr
    import pmp_pkg::*;
#(
    parameter int PMP_ADDR_W = 54,
    parameter int N_ENTRIES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_req,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [63:0] csr_wdata,
    input  logic [1:0]  priv,
    output logic        csr_ack,
    output logic [63:0] csr_rdata,
    output logic        csr_illegal,
    output logic        pmp_upd,
    output logic [63:0] pmpcfg0,
    output logic [63:0] pmpcfg2,
    output logic [63:0] pmpaddr0,
    output logic [63:0] pmpaddr1,
    output logic [63:0] pmpaddr2,
    output logic [63:0] pmpaddr3,
    output logic [63:0] pmpaddr4,
    output logic [63:0] pmpaddr5,
    output logic [63:0] pmpaddr6,
    output logic [63:0] pmpaddr7,
    output logic [63:0] pmpaddr8,
    output logic [63:0] pmpaddr9,
    output logic [63:0] pmpaddr10,
    output logic [63:0] pmpaddr11,
    output logic [63:0] pmpaddr12,
    output logic [63:0] pmpaddr13,
    output logic [63:0] pmpaddr14,
    output logic [63:0] pmpaddr15
);

    localparam logic [63:0] ADDR_MASK = {{(64-PMP_ADDR_W){1'b0}}, {PMP_ADDR_W{1'b1}}};

    logic [7:0]           cfg_q  [N_ENTRIES];
    logic [7:0]           cfg_d  [N_ENTRIES];
    logic [63:0]          addr_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] cfg_chg;
    logic [N_ENTRIES-1:0] cfg_we;
    logic [N_ENTRIES-1:0] addr_lock;

    logic        is_cfg, is_cfg_odd, is_addr, claimed, illegal;
    logic        wr_op, do_write, cfg_wr, addr_we, addr_chg;
    logic [3:0]  idx;
    logic [63:0] old_val, new_val, addr_wr_val;

    // ---------------- decode and read-modify-write ----------------
    always_comb begin
        idx        = csr_addr[3:0];
        is_cfg     = (csr_addr == PMPCFG0) || (csr_addr == PMPCFG2);
        is_cfg_odd = (csr_addr == (PMPCFG0 | 12'h001)) || (csr_addr == (PMPCFG2 | 12'h001));
        is_addr    = (csr_addr[11:4] == PMPADDR_BASE[11:4]);
        claimed    = csr_req && (is_cfg || is_cfg_odd || is_addr);
        illegal    = (priv != PRIV_M) || is_cfg_odd;

        // RS/RC with a zero operand are pure reads.
        wr_op    = (csr_op == OP_RW) || ((csr_op != OP_READ) && (csr_wdata != 64'd0));
        do_write = claimed && !illegal && wr_op;
        cfg_wr   = do_write && is_cfg;

        old_val = 64'd0;
        if (is_cfg) begin
            old_val = csr_addr[1] ? pmpcfg2 : pmpcfg0;
        end else if (is_addr) begin
            old_val = addr_q[idx];
        end
        new_val = csr_apply(csr_op, old_val, csr_wdata);

        addr_wr_val = new_val & ADDR_MASK;
        addr_we     = do_write && is_addr && !addr_lock[idx];
        addr_chg    = addr_we && (addr_wr_val != addr_q[idx]);
    end

    // ---------------- per-entry lock matrix and cfg lanes ----------------
    for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
        localparam logic HI = (i >= 8);

        // A locked TOR entry also freezes the address below it (its base).
        if (i < N_ENTRIES - 1) begin : g_tor
            assign addr_lock[i] = cfg_q[i][CFG_L] |
                                  (cfg_q[i+1][CFG_L] & (cfg_q[i+1][CFG_A_HI:CFG_A_LO] == A_TOR));
        end else begin : g_last
            assign addr_lock[i] = cfg_q[i][CFG_L];
        end

        assign cfg_we[i] = cfg_wr & (csr_addr[1] == HI) & ~cfg_q[i][CFG_L];

        pmp_cfg_lane u_lane (
            .old_cfg (cfg_q[i]),
            .new_cfg (new_val[8*(i%8) +: 8]),
            .wr_en   (cfg_we[i]),
            .cfg_out (cfg_d[i]),
            .changed (cfg_chg[i])
        );
    end

    // ---------------- state and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ENTRIES; k++) begin
                cfg_q[k]  <= 8'd0;
                addr_q[k] <= 64'd0;
            end
            csr_ack     <= 1'b0;
            csr_rdata   <= 64'd0;
            csr_illegal <= 1'b0;
            pmp_upd     <= 1'b0;
        end else begin
            for (int k = 0; k < N_ENTRIES; k++) begin
                cfg_q[k] <= cfg_d[k];
            end
            if (addr_we) begin
                addr_q[idx] <= addr_wr_val;
            end
            csr_ack     <= claimed;
            csr_illegal <= claimed && illegal;
            csr_rdata   <= (claimed && !illegal) ? old_val : 64'd0;
            pmp_upd     <= (|cfg_chg) || addr_chg;
        end
    end

    // ---------------- flat output buses ----------------
    for (genvar g = 0; g < 8; g++) begin : g_flat
        assign pmpcfg0[8*g +: 8] = cfg_q[g];
        assign pmpcfg2[8*g +: 8] = cfg_q[g+8];
    end

    assign pmpaddr0  = addr_q[0];
    assign pmpaddr1  = addr_q[1];
    assign pmpaddr2  = addr_q[2];
    assign pmpaddr3  = addr_q[3];
    assign pmpaddr4  = addr_q[4];
    assign pmpaddr5  = addr_q[5];
    assign pmpaddr6  = addr_q[6];
    assign pmpaddr7  = addr_q[7];
    assign pmpaddr8  = addr_q[8];
    assign pmpaddr9  = addr_q[9];
    assign pmpaddr10 = addr_q[10];
    assign pmpaddr11 = addr_q[11];
    assign pmpaddr12 = addr_q[12];
    assign pmpaddr13 = addr_q[13];
    assign pmpaddr14 = addr_q[14];
    assign pmpaddr15 = addr_q[15];

endmodule

// File: tb/tb_pmp_csr.sv
// Bench for pmp_csr: reference model + response scoreboard.
// Requests are driven on the falling edge; responses checked one cycle later.
module tb_pmp_csr;
    import pmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_req = 1'b0;
    logic [11:0] csr_addr = 12'd0;
    logic [1:0]  csr_op = 2'd0;
    logic [63:0] csr_wdata = 64'd0;
    logic [1:0]  priv = 2'b11;
    logic        csr_ack, csr_illegal, pmp_upd;
    logic [63:0] csr_rdata, pmpcfg0, pmpcfg2;
    logic [63:0] dut_addr [16];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic             illegal;
        logic [63:0]      rdata;
        logic             upd;
        logic [63:0]      cfg0;
        logic [63:0]      cfg2;
        logic [15:0][63:0] addr;
        logic [31:0]      due;
    } exp_t;

    exp_t sb[$];

    logic [7:0]  mcfg  [16];
    logic [63:0] maddr [16];

    pmp_csr dut (
        .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_addr(csr_addr),
        .csr_op(csr_op), .csr_wdata(csr_wdata), .priv(priv),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .pmp_upd(pmp_upd), .pmpcfg0(pmpcfg0), .pmpcfg2(pmpcfg2),
        .pmpaddr0(dut_addr[0]),   .pmpaddr1(dut_addr[1]),   .pmpaddr2(dut_addr[2]),
        .pmpaddr3(dut_addr[3]),   .pmpaddr4(dut_addr[4]),   .pmpaddr5(dut_addr[5]),
        .pmpaddr6(dut_addr[6]),   .pmpaddr7(dut_addr[7]),   .pmpaddr8(dut_addr[8]),
        .pmpaddr9(dut_addr[9]),   .pmpaddr10(dut_addr[10]), .pmpaddr11(dut_addr[11]),
        .pmpaddr12(dut_addr[12]), .pmpaddr13(dut_addr[13]), .pmpaddr14(dut_addr[14]),
        .pmpaddr15(dut_addr[15])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_cfg(input int base);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = mcfg[base+b];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            mcfg[k]  = 8'd0;
            maddr[k] = 64'd0;
        end
    endtask

    // Drive one request; model the expected response and post-state.
    task automatic drv(input logic [1:0] op, input logic [11:0] a,
                       input logic [63:0] wd, input logic [1:0] pv);
        exp_t        e;
        logic        claim, ill, wr, chg, lk;
        logic [63:0] oldv, nv, na;
        logic [7:0]  nb;
        int          base, i;
        @(negedge clk);
        claim = (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF);
        ill   = (pv != 2'b11) || (a == 12'h3A1) || (a == 12'h3A3);
        chg   = 1'b0;
        oldv  = 64'd0;
        if (a == 12'h3A0)      oldv = m_cfg(0);
        else if (a == 12'h3A2) oldv = m_cfg(8);
        else if (a >= 12'h3B0 && a <= 12'h3BF) oldv = maddr[a[3:0]];
        if (claim && !ill) begin
            case (op)
                2'b01:   nv = wd;
                2'b10:   nv = oldv | wd;
                2'b11:   nv = oldv & ~wd;
                default: nv = oldv;
            endcase
            wr = (op == 2'b01) || (op != 2'b00 && wd != 64'd0);
            if (wr && (a == 12'h3A0 || a == 12'h3A2)) begin
                base = (a == 12'h3A2) ? 8 : 0;
                for (int b = 0; b < 8; b++) begin
                    if (!mcfg[base+b][7]) begin
                        nb = nv[8*b +: 8];
                        nb[6:5] = 2'b00;
                        if (!nb[0] && nb[1]) nb[1] = 1'b0;
                        if (nb != mcfg[base+b]) chg = 1'b1;
                        mcfg[base+b] = nb;
                    end
                end
            end else if (wr && a >= 12'h3B0) begin
                i  = int'(a[3:0]);
                lk = mcfg[i][7];
                if (i < 15) lk = lk || (mcfg[i+1][7] && mcfg[i+1][4:3] == 2'b01);
                if (!lk) begin
                    na = nv & 64'h003F_FFFF_FFFF_FFFF;
                    if (na != maddr[i]) chg = 1'b1;
                    maddr[i] = na;
                end
            end
        end
        if (claim) begin
            e.illegal = ill;
            e.rdata   = ill ? 64'd0 : oldv;
            e.upd     = chg;
            e.cfg0    = m_cfg(0);
            e.cfg2    = m_cfg(8);
            for (int k = 0; k < 16; k++) e.addr[k] = maddr[k];
            e.due     = cyc + 1;
            sb.push_back(e);
        end
        csr_req   = 1'b1;
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = wd;
        priv      = pv;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        csr_req = 1'b0;
        priv    = 2'b11;
    endtask

    // Response monitor.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("ack",     64'(csr_ack),     64'd1);
                chk("illegal", 64'(csr_illegal), 64'(e.illegal));
                chk("rdata",   csr_rdata,        e.rdata);
                chk("pmp_upd", 64'(pmp_upd),     64'(e.upd));
                chk("pmpcfg0", pmpcfg0,          e.cfg0);
                chk("pmpcfg2", pmpcfg2,          e.cfg2);
                for (int k = 0; k < 16; k++)
                    chk($sformatf("pmpaddr%0d", k), dut_addr[k], e.addr[k]);
            end else begin
                if (csr_ack) chk("spurious_ack", 64'(csr_ack), 64'd0);
                if (pmp_upd) chk("spurious_upd", 64'(pmp_upd), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack",     64'(csr_ack), 64'd0);
        chk("rst_rdata",   csr_rdata,    64'd0);
        chk("rst_illegal", 64'(csr_illegal), 64'd0);
        chk("rst_upd",     64'(pmp_upd), 64'd0);
        chk("rst_cfg0",    pmpcfg0,      64'd0);
        rst_n = 1'b1;

        // 1. read after reset
        drv(OP_READ, 12'h3A0, 64'd0, 2'b11);
        // 2. write then read back
        drv(OP_RW, 12'h3A0, 64'h1F1F, 2'b11);
        drv(OP_READ, 12'h3A0, 64'd0, 2'b11);
        idle();
        chk("cfg0_1f1f", pmpcfg0, 64'h1F1F);
        // 3. reserved R=0/W=1, then address upper-bit masking
        drv(OP_RW, 12'h3A0, 64'd0, 2'b11);
        drv(OP_RW, 12'h3A0, 64'h02, 2'b11);
        drv(OP_RW, 12'h3B0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
        idle();
        chk("cfg0_w_only", pmpcfg0, 64'd0);
        chk("addr0_max", dut_addr[0], 64'h003F_FFFF_FFFF_FFFF);
        // 4. locked entry 1
        drv(OP_RW, 12'h3A0, 64'h8F00, 2'b11);
        drv(OP_RW, 12'h3B1, 64'h1234, 2'b11);
        drv(OP_RC, 12'h3A0, 64'hFF00, 2'b11);
        idle();
        chk("cfg1_locked", pmpcfg0 & 64'hFF00, 64'h8F00);
        chk("addr1_locked", dut_addr[1], 64'd0);
        // 5. locked TOR on entry 3 freezes pmpaddr2 and pmpaddr3
        drv(OP_RW, 12'h3A0, 64'h8800_0000, 2'b11);
        drv(OP_RW, 12'h3B2, 64'h55, 2'b11);
        drv(OP_RW, 12'h3B3, 64'h55, 2'b11);
        drv(OP_RW, 12'h3B4, 64'h55, 2'b11);
        idle();
        chk("addr2_tor_lock", dut_addr[2], 64'd0);
        chk("addr3_lock", dut_addr[3], 64'd0);
        chk("addr4_written", dut_addr[4], 64'h55);
        // 6. illegal accesses, unclaimed address, back-to-back RS
        drv(OP_RW, 12'h3A2, 64'h0F0F, 2'b01);
        drv(OP_RW, 12'h3A1, 64'h0F0F, 2'b11);
        drv(OP_RW, 12'h300, 64'h0F0F, 2'b11);
        drv(OP_RS, 12'h3B5, 64'h1, 2'b11);
        drv(OP_RS, 12'h3B5, 64'h2, 2'b11);
        drv(OP_RS, 12'h3B5, 64'h0, 2'b11);
        drv(OP_RW, 12'h3A2, 64'h6A02_FF7F, 2'b11);
        drv(OP_READ, 12'h3A2, 64'd0, 2'b11);
        idle();
        chk("addr5_rs", dut_addr[5], 64'h3);
        chk("cfg2_warl", pmpcfg2, 64'h0800_9F1F);

        // random mixed traffic
        for (int n = 0; n < 60; n++) begin
            int          r;
            logic [11:0] a;
            logic [1:0]  pv;
            r  = $urandom_range(0, 20);
            if (r == 0)      a = 12'h3A0;
            else if (r == 1) a = 12'h3A2;
            else if (r == 2) a = 12'h3A1;
            else if (r == 3) a = 12'h3A3;
            else if (r == 4) a = 12'h3C0;
            else             a = 12'h3B0 + 12'(r - 5);
            pv = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b11;
            drv(2'($urandom_range(0, 3)), a, {$urandom, $urandom}, pv);
        end

        // reset in the middle of a response
        drv(OP_RW, 12'h3BF, 64'hABCD, 2'b11);
        #2;
        chk("pre_rst_ack", 64'(csr_ack), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("mid_rst_ack",   64'(csr_ack), 64'd0);
        chk("mid_rst_rdata", csr_rdata,    64'd0);
        chk("mid_rst_upd",   64'(pmp_upd), 64'd0);
        chk("mid_rst_cfg0",  pmpcfg0,      64'd0);
        chk("mid_rst_cfg2",  pmpcfg2,      64'd0);
        chk("mid_rst_addr15", dut_addr[15], 64'd0);
        chk("mid_rst_addr5", dut_addr[5],  64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drv(OP_READ, 12'h3B5, 64'd0, 2'b11);
        idle();
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
